// File: rtl/axi_bram_responder_pkg.sv
// Shared definitions for the AXI block-RAM responder: AXI response and burst
// encodings, the responder state enum and the write-response merge helper.
package axi_bram_responder_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_DATA  = 3'd1,
        ST_WR_RESP  = 3'd2,
        ST_RD_FETCH = 3'd3,
        ST_RD_DATA  = 3'd4
    } resp_state_t;

    // A decode error anywhere in the burst outranks a wlast framing error.
    function automatic logic [1:0] write_resp(input logic dec_err, input logic slv_err);
        if (dec_err) return AXI_RESP_DECERR;
        if (slv_err) return AXI_RESP_SLVERR;
        return AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_bram_responder_if.sv
// AXI4 bus subset seen by the block-RAM responder (no size/lock/cache/prot/qos).
// Every channel uses AXI valid/ready: a transfer happens on a rising clk edge
// where valid and ready are both high; a source holds its payload stable and
// keeps valid high until that edge, and valid never waits on ready.
interface axi_bram_responder_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [1:0]          awburst;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [1:0]          arburst;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport slave (
        input  awid, awaddr, awlen, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arburst, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awid, awaddr, awlen, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arburst, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

endinterface

// File: rtl/axi_bram_responder_bram.sv
// bram_bytewise: single-port synchronous RAM with per-byte write enables and
// a one-cycle registered read (read-first), written for FPGA BRAM inference.
module bram_bytewise #(
    parameter int DATA_W = 128,
    parameter int DEPTH  = 4096,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [AW-1:0]       addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-masked write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < DATA_W / 8; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axi_bram_responder.sv
// axi_bram_responder: AXI4 slave backed by an internal block RAM. Serves one
// transaction at a time (single beats, INCR and FIXED bursts; WRAP and the
// reserved encoding behave as INCR). Reads deliver one beat every two cycles.
module axi_bram_responder
    import axi_bram_responder_pkg::*;
#(
    parameter int ADDR_W    = 28,
    parameter int DATA_W    = 128,
    parameter int ID_W      = 4,
    parameter int MEM_DEPTH = 4096
) (
    input  logic                 clk,
    input  logic                 nrst,
    axi_bram_responder_if.slave  s_axi,
    output resp_state_t          dbg_state
);
    localparam int IDX_W  = ADDR_W - 4;
    localparam int STRB_W = DATA_W / 8;
    localparam int MEM_AW = $clog2(MEM_DEPTH);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(MEM_DEPTH);

    resp_state_t       state;
    logic              rr_read_next;
    logic [ID_W-1:0]   id_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        len_q;
    logic [7:0]        cnt_q;
    logic [1:0]        burst_q;
    logic              dec_err_q;
    logic              last_err_q;

    logic              wready_q;
    logic              bvalid_q;
    logic [ID_W-1:0]   bid_q;
    logic [1:0]        bresp_q;
    logic              rvalid_q;
    logic [ID_W-1:0]   rid_q;
    logic [1:0]        rresp_q;
    logic              rlast_q;

    logic              sel_wr;
    logic              sel_rd;
    logic              aw_hs;
    logic              ar_hs;
    logic              w_beat;
    logic              is_last;
    logic              in_range;
    logic [IDX_W-1:0]  idx_next;

    logic              ram_en;
    logic [STRB_W-1:0] ram_we;
    logic [MEM_AW-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;

    // The low address nibble selects a byte inside a 16-byte beat and is ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi.awaddr[3:0], s_axi.araddr[3:0]};

    // Arbitration: a lone request wins; on a tie the round-robin flag decides.
    assign sel_rd = s_axi.arvalid && (!s_axi.awvalid || rr_read_next);
    assign sel_wr = s_axi.awvalid && (!s_axi.arvalid || !rr_read_next);

    assign s_axi.awready = (state == ST_IDLE) && sel_wr;
    assign s_axi.arready = (state == ST_IDLE) && sel_rd;
    assign aw_hs         = s_axi.awvalid && s_axi.awready;
    assign ar_hs         = s_axi.arvalid && s_axi.arready;

    assign w_beat   = (state == ST_WR_DATA) && s_axi.wvalid && wready_q;
    assign is_last  = (cnt_q == len_q);
    assign in_range = (idx_q < DEPTH_IDX);
    assign idx_next = (burst_q == AXI_BURST_FIXED) ? idx_q : idx_q + IDX_W'(1);

    assign s_axi.wready  = wready_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bid     = bid_q;
    assign s_axi.bresp   = bresp_q;
    assign s_axi.rvalid  = rvalid_q;
    assign s_axi.rid     = rid_q;
    assign s_axi.rresp   = rresp_q;
    assign s_axi.rlast   = rlast_q;
    // The RAM is idle throughout RD_DATA, so its output register holds the
    // beat under backpressure; decode-error and idle beats read as zero.
    assign s_axi.rdata   = (rvalid_q && rresp_q == AXI_RESP_OKAY) ? ram_rdata : '0;
    assign dbg_state     = state;

    // RAM port: fetch in RD_FETCH, byte-masked write on in-range W beats.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = '0;
        ram_addr = idx_q[MEM_AW-1:0];
        if (state == ST_RD_FETCH) begin
            ram_en = in_range;
        end
        if (w_beat && in_range) begin
            ram_en = 1'b1;
            ram_we = s_axi.wstrb;
        end
    end

    bram_bytewise #(
        .DATA_W (DATA_W),
        .DEPTH  (MEM_DEPTH),
        .AW     (MEM_AW)
    ) u_bram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (s_axi.wdata),
        .rdata (ram_rdata)
    );

    // Transaction FSM with registered channel outputs.
    always_ff @(posedge clk) begin
        if (nrst) begin
            state        <= ST_IDLE;
            rr_read_next <= 1'b1;
            id_q         <= '0;
            idx_q        <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            burst_q      <= AXI_BURST_INCR;
            dec_err_q    <= 1'b0;
            last_err_q   <= 1'b0;
            wready_q     <= 1'b0;
            bvalid_q     <= 1'b0;
            bid_q        <= '0;
            bresp_q      <= AXI_RESP_OKAY;
            rvalid_q     <= 1'b0;
            rid_q        <= '0;
            rresp_q      <= AXI_RESP_OKAY;
            rlast_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (aw_hs) begin
                        id_q         <= s_axi.awid;
                        idx_q        <= s_axi.awaddr[ADDR_W-1:4];
                        len_q        <= s_axi.awlen;
                        burst_q      <= s_axi.awburst;
                        cnt_q        <= '0;
                        dec_err_q    <= 1'b0;
                        last_err_q   <= 1'b0;
                        wready_q     <= 1'b1;
                        rr_read_next <= ~rr_read_next;
                        state        <= ST_WR_DATA;
                    end else if (ar_hs) begin
                        id_q         <= s_axi.arid;
                        idx_q        <= s_axi.araddr[ADDR_W-1:4];
                        len_q        <= s_axi.arlen;
                        burst_q      <= s_axi.arburst;
                        cnt_q        <= '0;
                        dec_err_q    <= 1'b0;
                        last_err_q   <= 1'b0;
                        rr_read_next <= ~rr_read_next;
                        state        <= ST_RD_FETCH;
                    end
                end
                ST_WR_DATA: begin
                    if (w_beat) begin
                        if (!in_range) begin
                            dec_err_q <= 1'b1;
                        end
                        if (s_axi.wlast && !is_last) begin
                            last_err_q <= 1'b1;
                        end
                        idx_q <= idx_next;
                        cnt_q <= cnt_q + 8'd1;
                        if (is_last) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= write_resp(dec_err_q || !in_range,
                                                   last_err_q || !s_axi.wlast);
                            state    <= ST_WR_RESP;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi.bready) begin
                        bvalid_q <= 1'b0;
                        state    <= ST_IDLE;
                    end
                end
                ST_RD_FETCH: begin
                    rvalid_q <= 1'b1;
                    rid_q    <= id_q;
                    rresp_q  <= in_range ? AXI_RESP_OKAY : AXI_RESP_DECERR;
                    rlast_q  <= is_last;
                    state    <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (s_axi.rready) begin
                        rvalid_q <= 1'b0;
                        if (rlast_q) begin
                            state <= ST_IDLE;
                        end else begin
                            idx_q <= idx_next;
                            cnt_q <= cnt_q + 8'd1;
                            state <= ST_RD_FETCH;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_bram_responder.sv
// Directed bench for axi_bram_responder: drivers issue AXI transactions and
// push hand-computed B/R responses into queues; a negedge monitor pops and
// compares every B and R handshake and checks R stability under backpressure.
module tb_axi_bram_responder;
    import axi_bram_responder_pkg::*;

    localparam int ADDR_W    = 28;
    localparam int DATA_W    = 128;
    localparam int ID_W      = 4;
    localparam int MEM_DEPTH = 4096;
    localparam int R_W       = ID_W + 2 + 1 + DATA_W;
    localparam int B_W       = ID_W + 2;

    logic        clk = 1'b0;
    logic        nrst;
    resp_state_t dbg_state;

    axi_bram_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_axi ();

    axi_bram_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MEM_DEPTH(MEM_DEPTH)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .s_axi     (s_axi),
        .dbg_state (dbg_state)
    );

    // Clock and counters.
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [R_W-1:0] exp_r_q[$];
    logic [B_W-1:0] exp_b_q[$];

    logic [DATA_W-1:0]   wbuf [8];
    logic [DATA_W/8-1:0] sbuf [8];
    logic                lbuf [8];
    logic                rpat [4];
    int                  rpat_len;
    int                  last_lat;
    time                 aw_hs_t;
    time                 ar_hs_t;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_r(input logic [ID_W-1:0] id, input logic [1:0] resp,
                          input logic last, input logic [DATA_W-1:0] data);
        exp_r_q.push_back({id, resp, last, data});
    endtask

    // Monitor: B/R scoreboard, R hold check, address-ready exclusivity.
    logic [R_W-1:0] r_exp;
    logic [R_W-1:0] r_held;
    logic           r_held_v = 1'b0;
    logic [B_W-1:0] b_exp;

    always @(negedge clk) begin
        if (nrst) begin
            r_held_v = 1'b0;
        end else begin
            if (s_axi.bvalid && s_axi.bready) begin
                if (exp_b_q.size() == 0) begin
                    check("b_unexpected", 160'(1), 160'(0));
                end else begin
                    b_exp = exp_b_q.pop_front();
                    check("b_resp", 160'({s_axi.bid, s_axi.bresp}), 160'(b_exp));
                end
            end
            if (s_axi.rvalid) begin
                if (r_held_v) begin
                    check("r_hold", 160'({s_axi.rid, s_axi.rresp, s_axi.rlast, s_axi.rdata}),
                          160'(r_held));
                end
                r_held   = {s_axi.rid, s_axi.rresp, s_axi.rlast, s_axi.rdata};
                r_held_v = !s_axi.rready;
            end else begin
                r_held_v = 1'b0;
            end
            if (s_axi.rvalid && s_axi.rready) begin
                if (exp_r_q.size() == 0) begin
                    check("r_unexpected", 160'(1), 160'(0));
                end else begin
                    r_exp = exp_r_q.pop_front();
                    check("r_beat", 160'({s_axi.rid, s_axi.rresp, s_axi.rlast, s_axi.rdata}),
                          160'(r_exp));
                end
            end
            if (s_axi.awready || s_axi.arready) begin
                check("addr_ready_excl", 160'(s_axi.awready && s_axi.arready), 160'(0));
                check("addr_ready_idle", 160'(dbg_state), 160'(ST_IDLE));
            end
        end
    end

    // Driver tasks.
    task automatic do_reset();
        @(posedge clk); #1;
        nrst = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b0;
    endtask

    task automatic aw_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic hs = 1'b0;
        s_axi.awid    = id;
        s_axi.awaddr  = addr;
        s_axi.awlen   = len;
        s_axi.awburst = burst;
        s_axi.awvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            hs = s_axi.awready;
            @(posedge clk);
            if (hs) aw_hs_t = $time;
            #1;
            if (hs) break;
        end
        s_axi.awvalid = 1'b0;
        if (!hs) check("aw_timeout", 160'(0), 160'(1));
    endtask

    task automatic ar_send(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic hs = 1'b0;
        s_axi.arid    = id;
        s_axi.araddr  = addr;
        s_axi.arlen   = len;
        s_axi.arburst = burst;
        s_axi.arvalid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            hs = s_axi.arready;
            @(posedge clk);
            if (hs) ar_hs_t = $time;
            #1;
            if (hs) break;
        end
        s_axi.arvalid = 1'b0;
        if (!hs) check("ar_timeout", 160'(0), 160'(1));
    endtask

    task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] len, input logic [1:0] burst,
                            input logic [1:0] bresp_exp);
        logic got;
        exp_b_q.push_back({id, bresp_exp});
        aw_send(id, addr, len, burst);
        for (int i = 0; i <= int'(len); i++) begin
            got = 1'b0;
            s_axi.wdata  = wbuf[i];
            s_axi.wstrb  = sbuf[i];
            s_axi.wlast  = lbuf[i];
            s_axi.wvalid = 1'b1;
            for (int c = 0; c < 200; c++) begin
                @(negedge clk);
                got = s_axi.wready;
                @(posedge clk); #1;
                if (got) break;
            end
            if (!got) check("w_timeout", 160'(0), 160'(1));
        end
        s_axi.wvalid = 1'b0;
        s_axi.wlast  = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            got = s_axi.bvalid && s_axi.bready;
            @(posedge clk); #1;
            if (got) break;
        end
        if (!got) check("b_timeout", 160'(0), 160'(1));
    endtask

    task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                           input logic [7:0] len, input logic [1:0] burst);
        logic done = 1'b0;
        int   p    = 0;
        last_lat = -1;
        ar_send(id, addr, len, burst);
        for (int k = 0; k < 400; k++) begin
            s_axi.rready = rpat[p % rpat_len];
            @(negedge clk);
            if (s_axi.rvalid) begin
                if (last_lat < 0) last_lat = k + 1;
                done = s_axi.rready && s_axi.rlast;
                p++;
            end
            @(posedge clk); #1;
            if (done) break;
        end
        s_axi.rready = 1'b0;
        if (!done) check("r_timeout", 160'(0), 160'(1));
    endtask

    task automatic set_rpat_all_ones();
        rpat[0]  = 1'b1;
        rpat_len = 1;
    endtask

    // Directed sequence.
    initial begin
        logic [DATA_W-1:0] d_a;
        logic got;
        s_axi.awvalid = 1'b0; s_axi.awid = '0; s_axi.awaddr = '0; s_axi.awlen = '0;
        s_axi.awburst = AXI_BURST_INCR;
        s_axi.wvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
        s_axi.bready = 1'b1;
        s_axi.arvalid = 1'b0; s_axi.arid = '0; s_axi.araddr = '0; s_axi.arlen = '0;
        s_axi.arburst = AXI_BURST_INCR;
        s_axi.rready = 1'b0;
        set_rpat_all_ones();
        nrst = 1'b1;
        repeat (3) @(posedge clk);
        #1 nrst = 1'b0;

        // Reset state.
        @(negedge clk);
        check("rst_state", 160'(dbg_state), 160'(ST_IDLE));
        check("rst_readys", 160'({s_axi.awready, s_axi.arready, s_axi.wready}), 160'(0));
        check("rst_valids", 160'({s_axi.bvalid, s_axi.rvalid}), 160'(0));
        check("rst_b", 160'({s_axi.bid, s_axi.bresp}), 160'(0));
        check("rst_r", 160'({s_axi.rid, s_axi.rresp, s_axi.rlast}), 160'(0));
        check("rst_rdata", 160'(s_axi.rdata), 160'(0));
        @(posedge clk); #1;

        // Single write then read.
        d_a = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
        wbuf[0] = d_a; sbuf[0] = '1; lbuf[0] = 1'b1;
        do_write(4'd3, 28'h000_0040, 8'd0, AXI_BURST_INCR, AXI_RESP_OKAY);
        push_r(4'd3, AXI_RESP_OKAY, 1'b1, d_a);
        do_read(4'd3, 28'h000_0040, 8'd0, AXI_BURST_INCR);
        check("rd_latency", 160'(last_lat), 160'(2));

        // Byte strobes on word 5.
        wbuf[0] = '1; sbuf[0] = '1; lbuf[0] = 1'b1;
        do_write(4'd1, 28'h000_0050, 8'd0, AXI_BURST_INCR, AXI_RESP_OKAY);
        wbuf[0] = '0; sbuf[0] = 16'h000F;
        do_write(4'd1, 28'h000_0050, 8'd0, AXI_BURST_INCR, AXI_RESP_OKAY);
        push_r(4'd1, AXI_RESP_OKAY, 1'b1, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'h0});
        do_read(4'd1, 28'h000_0050, 8'd0, AXI_BURST_INCR);

        // INCR burst with rready toggling 1,0,1.
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 128'(i + 1); sbuf[i] = '1; lbuf[i] = (i == 3);
        end
        do_write(4'd5, 28'h000_0100, 8'd3, AXI_BURST_INCR, AXI_RESP_OKAY);
        push_r(4'd5, AXI_RESP_OKAY, 1'b0, 128'd1);
        push_r(4'd5, AXI_RESP_OKAY, 1'b0, 128'd2);
        push_r(4'd5, AXI_RESP_OKAY, 1'b0, 128'd3);
        push_r(4'd5, AXI_RESP_OKAY, 1'b1, 128'd4);
        rpat[0] = 1'b1; rpat[1] = 1'b0; rpat[2] = 1'b1; rpat_len = 3;
        do_read(4'd5, 28'h000_0100, 8'd3, AXI_BURST_INCR);
        set_rpat_all_ones();

        // FIXED burst: both beats land on the same word.
        wbuf[0] = 128'h77; wbuf[1] = 128'h88; sbuf[0] = '1; sbuf[1] = '1;
        lbuf[0] = 1'b0; lbuf[1] = 1'b1;
        do_write(4'd4, 28'h000_0600, 8'd1, AXI_BURST_FIXED, AXI_RESP_OKAY);
        push_r(4'd4, AXI_RESP_OKAY, 1'b0, 128'h88);
        push_r(4'd4, AXI_RESP_OKAY, 1'b1, 128'h88);
        do_read(4'd4, 28'h000_0600, 8'd1, AXI_BURST_FIXED);

        // Out of range: read at index MEM_DEPTH, write straddling the top.
        push_r(4'd6, AXI_RESP_DECERR, 1'b1, 128'h0);
        do_read(4'd6, 28'h001_0000, 8'd0, AXI_BURST_INCR);
        wbuf[0] = {4{32'hAAAA_5555}}; wbuf[1] = {4{32'h1234_5678}};
        sbuf[0] = '1; sbuf[1] = '1; lbuf[0] = 1'b0; lbuf[1] = 1'b1;
        do_write(4'd7, 28'h000_FFF0, 8'd1, AXI_BURST_INCR, AXI_RESP_DECERR);
        push_r(4'd7, AXI_RESP_OKAY, 1'b0, {4{32'hAAAA_5555}});
        push_r(4'd7, AXI_RESP_DECERR, 1'b1, 128'h0);
        do_read(4'd7, 28'h000_FFF0, 8'd1, AXI_BURST_INCR);

        // Arbitration: preload, reset the round-robin flag, then two ties.
        wbuf[0] = 128'hA0; sbuf[0] = '1; lbuf[0] = 1'b1;
        do_write(4'd2, 28'h000_0200, 8'd0, AXI_BURST_INCR, AXI_RESP_OKAY);
        do_reset();
        wbuf[0] = 128'hB0;
        push_r(4'd2, AXI_RESP_OKAY, 1'b1, 128'hA0);
        fork
            do_write(4'd1, 28'h000_0200, 8'd0, AXI_BURST_INCR, AXI_RESP_OKAY);
            do_read(4'd2, 28'h000_0200, 8'd0, AXI_BURST_INCR);
        join
        check("arb1_read_first", 160'(ar_hs_t < aw_hs_t), 160'(1));
        wbuf[0] = 128'hC0;
        push_r(4'd2, AXI_RESP_OKAY, 1'b1, 128'hB0);
        fork
            do_write(4'd1, 28'h000_0200, 8'd0, AXI_BURST_INCR, AXI_RESP_OKAY);
            do_read(4'd2, 28'h000_0200, 8'd0, AXI_BURST_INCR);
        join
        check("arb2_read_first", 160'(ar_hs_t < aw_hs_t), 160'(1));

        // wlast framing errors.
        wbuf[0] = 128'h1; wbuf[1] = 128'h2; sbuf[0] = '1; sbuf[1] = '1;
        lbuf[0] = 1'b1; lbuf[1] = 1'b1;
        do_write(4'd8, 28'h000_0300, 8'd1, AXI_BURST_INCR, AXI_RESP_SLVERR);
        lbuf[0] = 1'b0; lbuf[1] = 1'b0;
        do_write(4'd8, 28'h000_0300, 8'd1, AXI_BURST_INCR, AXI_RESP_SLVERR);

        // Reset in the middle of a len-7 read.
        for (int i = 0; i < 8; i++) begin
            wbuf[i] = 128'(16 + i); sbuf[i] = '1; lbuf[i] = (i == 7);
        end
        do_write(4'd9, 28'h000_0400, 8'd7, AXI_BURST_INCR, AXI_RESP_OKAY);
        s_axi.rready = 1'b0;
        ar_send(4'd9, 28'h000_0400, 8'd7, AXI_BURST_INCR);
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            got = s_axi.rvalid;
            @(posedge clk); #1;
            if (got) break;
        end
        check("midrst_rvalid_seen", 160'(got), 160'(1));
        nrst = 1'b1;
        @(posedge clk); #1;
        nrst = 1'b0;
        @(negedge clk);
        check("midrst_rvalid", 160'(s_axi.rvalid), 160'(0));
        check("midrst_state", 160'(dbg_state), 160'(ST_IDLE));
        @(posedge clk); #1;
        push_r(4'd10, AXI_RESP_OKAY, 1'b0, 128'd16);
        push_r(4'd10, AXI_RESP_OKAY, 1'b1, 128'd17);
        do_read(4'd10, 28'h000_0400, 8'd1, AXI_BURST_INCR);

        // Drain and report.
        for (int c = 0; c < 50; c++) begin
            if (exp_r_q.size() == 0 && exp_b_q.size() == 0) break;
            @(negedge clk);
        end
        check("queues_drained", 160'(exp_r_q.size() + exp_b_q.size()), 160'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_bram_responder.md
Name: axi_bram_responder

Overview:
- AXI4 slave memory that answers the memory-management unit's AXI master port (s_axi_* bus): 28-bit address, 128-bit data, 4-bit ID.
- Backs the bus with an internal synchronous block RAM of MEM_DEPTH 128-bit words, with byte-strobe writes.
- Handles single-beat and INCR/FIXED bursts, one transaction at a time.
- Serves as on-chip data memory in FPGA builds and as the memory model in simulation.

Parameters:
- ADDR_W, 28, AXI address width.
- DATA_W, 128, beat width in bits; strobe width is DATA_W/8.
- ID_W, 4, AXI ID width.
- MEM_DEPTH, 4096, number of DATA_W words; must be a power of two.

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-high
- awid/awaddr/awlen/awburst  in  ID_W/ADDR_W/8/2  write address channel; awsize, lock, cache, prot and qos are not ported and are ignored.
- awvalid in 1; awready out 1
- wdata/wstrb/wlast/wvalid  in  DATA_W/DATA_W/8/1/1; wready out 1
- bid/bresp/bvalid  out  ID_W/2/1; bready in 1
- arid/araddr/arlen/arburst  in  ID_W/ADDR_W/8/2; arvalid in 1; arready out 1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/DATA_W/2/1/1; rready in 1

Behaviour:
- Reset (nrst=1 at a clk edge):
  - state goes to IDLE; all ready/valid outputs drop to 0.
  - bid, rid, bresp, rresp go to 0; rdata 0; rlast 0; round-robin flag goes to read-next.
  - Memory contents are not cleared.
  - A reset mid-burst abandons the transaction; no B or R beat is emitted for it.
- Address mapping:
  - word index = addr[ADDR_W-1:4]; addr[3:0] ignored (beats are always 16-byte aligned).
  - In range when index < MEM_DEPTH.
- Burst handling:
  - INCR (2'b01): index increments by 1 per beat.
  - FIXED (2'b00): index is constant.
  - WRAP (2'b10) and reserved (2'b11): treated as INCR.
  - Beat count = len+1, range 1..256.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_FETCH, RD_DATA.
- IDLE:
  - awready and arready are combinational: asserted only for the channel selected for this cycle.
  - If only awvalid is high, select write. If only arvalid is high, select read.
  - If both are high, the round-robin flag picks the channel, and the flag toggles after each accepted address.
  - On the handshake, latch id, index, len and burst; clear the beat counter and the error flag.
  - Write goes to WR_DATA; read goes to RD_FETCH.
- WR_DATA:
  - wready=1.
  - On each wvalid beat: if in range, write the bytes whose wstrb bit is set (byte i = wdata[8i+7:8i]); if out of range, drop the beat and set err=DECERR.
  - Advance index and counter.
  - On beat count==len: go to WR_RESP. If wlast is 0 on that beat, or wlast arrived earlier, set SLVERR (unless DECERR already recorded; DECERR dominates).
- WR_RESP:
  - bvalid=1, bid=latched id, bresp = OKAY 2'b00 / SLVERR 2'b10 / DECERR 2'b11.
  - Held stable until bready; then go to IDLE.
  - awready is 0 until IDLE is re-entered.
- RD_FETCH:
  - One cycle: issue the synchronous RAM read for the current index; go to RD_DATA.
- RD_DATA:
  - rvalid=1; rdata = RAM output, registered so it stays stable under backpressure.
  - rresp = DECERR with rdata=0 when out of range, else OKAY.
  - rid = latched id; rlast = (counter==len).
  - On rready: if last, go to IDLE; else advance index and counter and go to RD_FETCH.
  - Throughput is one beat per two cycles. First rvalid appears 2 cycles after the AR handshake.
- Write-to-read ordering:
  - A read accepted after a write's B handshake observes that write.
  - Only one transaction is outstanding, so no other hazards exist.
- Address acceptance:
  - awready and arready are never high in the same cycle.
  - Neither is high outside IDLE.

Decomposition:
- Shared package fcpu_pkg gets:
  - AXI response constants AXI_RESP_OKAY/SLVERR/DECERR.
  - Burst constants AXI_BURST_FIXED/INCR/WRAP.
  - The responder state enum.
- One sub-module: bram_bytewise (simple dual-use single-port RAM, DATA_W/8 byte enables, 1-cycle registered read, DEPTH parameter) for clean FPGA BRAM inference.

Test Plan:
- Single write, then read:
  - Stimulus: AW addr 0x0000040 len 0 id 3; W data 0x...DEADBEEF, strb 0xFFFF, wlast; bready=1; then AR addr 0x0000040.
  - Required: bresp 00, bid 3; rdata 0x...DEADBEEF, rlast 1, rid 3, rvalid 2 cycles after the AR handshake.
- Byte strobe:
  - Stimulus: write all-ones to word 5, then write 0 with strb 0x000F, then read word 5.
  - Required: rdata = 0xFFFF...FFFF_0000_0000.
- INCR burst:
  - Stimulus: AW len 3 at 0x100 with data 1,2,3,4; then AR len 3 at 0x100 with rready toggling 1,0,1.
  - Required: R beats 1,2,3,4 with rlast only on the 4th; each rdata is held while rready=0.
- Out of range:
  - Stimulus: AR at index MEM_DEPTH; write burst len 1 starting at index MEM_DEPTH-1.
  - Required: rresp 11 with rdata 0; bresp 11; word MEM_DEPTH-1 updated and the second beat dropped.
- Arbitration and wlast error:
  - Stimulus: awvalid and arvalid asserted together, twice in a row; then a write with len 1 where wlast is high on beat 0.
  - Required: read served first, then write; bresp 10 for the wlast case.
- Reset mid-burst:
  - Stimulus: assert nrst during RD_DATA of a len-7 read.
  - Required: next cycle rvalid=0 and state is IDLE; a subsequent read returns correct data.
